// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle between the requesters, the arbiter and the shared UART transmitter.
//   req         per-requester level request, held until its ack
//   req_data    byte per requester, requester i at [8i+7:8i]
//   ack         one-cycle completion pulse to the granted requester
//   tx_data     latched byte presented to the transmitter
//   tx_start    one-cycle start pulse to the transmitter
//   tx_busy     transmitter busy, high for the whole frame
//   grant_id    index of the current or last granted requester
//   busy        arbiter not idle
//   err_timeout sticky watchdog flag
//   clr_err     synchronous clear of err_timeout
// Modport slave is the arbiter side; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [IDX_W-1:0]  grant_id;
  logic              busy;
  logic              err_timeout;
  logic              clr_err;

  modport slave (
    input  req, req_data, tx_busy, clr_err,
    output ack, tx_data, tx_start, grant_id, busy, err_timeout
  );

  modport master (
    output req, req_data, tx_busy, clr_err,
    input  ack, tx_data, tx_start, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter between NREQ requesters.
// A granted requester's byte is latched, the transmitter is started with a one-cycle pulse,
// its busy flag is tracked, and the requester gets a one-cycle ack when the frame is done.
// A watchdog abandons (and still acks) a frame whose transmitter never goes busy.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (request, transmitter and status signals)
// All outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  // One counter serves both the watchdog and the post-frame gap; it only counts to N-1.
  localparam int unsigned CntMax = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StComplete,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              expire;
  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  int unsigned       idx;

  // Round-robin search from ptr+1 upward with wrap. Iterating offsets from largest to
  // smallest lets the nearest set request win by being written last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      idx = (32'(ptr_q) + off) % NREQ;
      if (bus.req[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // State register (including registered outputs).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      grant_q <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    expire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StLaunch;
          grant_d = pick;
          data_d  = bus.req_data[int'(pick)*8 +: 8];
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = StComplete;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) state_d = StComplete;
      end
      StComplete: begin
        ptr_d   = grant_q;
        cnt_d   = '0;
        state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: outputs are decoded from the next state so they are valid in the cycle
  // the FSM occupies that state, while still coming straight from flops.
  always_comb begin
    start_d = (state_d == StLaunch);
    busy_d  = (state_d != StIdle);
    ack_d   = '0;
    if (state_d == StComplete) ack_d[grant_q] = 1'b1;
    err_d = err_q;
    if (bus.clr_err) err_d = 1'b0;
    // Expiry overrides a simultaneous clear.
    if (expire) err_d = 1'b1;
  end

  assign bus.tx_start    = start_q;
  assign bus.tx_data     = data_q;
  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter. A behavioural transmitter raises tx_busy
// three cycles after seeing tx_start and holds it for 20 cycles. A second instance with
// GAP_CYCLES=0 checks back-to-back spacing.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4), .IDX_W(2)) bus ();
  uart_tx_arbiter_if #(.NREQ(4), .IDX_W(2)) bus0 ();

  uart_tx_arbiter #(.NREQ(4), .IDX_W(2), .ACK_TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  uart_tx_arbiter #(.NREQ(4), .IDX_W(2), .ACK_TIMEOUT(16), .GAP_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  int tests = 0;
  int fails = 0;

  // Transmitter models.
  bit model_en = 1'b0;
  int mcnt  = 0;
  int mcnt0 = 0;
  always @(posedge clk) begin
    if (!model_en) mcnt <= 0;
    else if (bus.tx_start) mcnt <= 1;
    else if (mcnt > 0) mcnt <= (mcnt == 23) ? 0 : mcnt + 1;
  end
  assign bus.tx_busy = model_en && (mcnt >= 3) && (mcnt < 23);

  always @(posedge clk) begin
    if (!rst_n) mcnt0 <= 0;
    else if (bus0.tx_start) mcnt0 <= 1;
    else if (mcnt0 > 0) mcnt0 <= (mcnt0 == 6) ? 0 : mcnt0 + 1;
  end
  assign bus0.tx_busy = (mcnt0 >= 2) && (mcnt0 < 6);

  // Event monitors.
  int start_cnt = 0;
  int ack_cnt   = 0;
  int overlap   = 0;
  always @(posedge clk) begin
    if (bus.tx_start) start_cnt <= start_cnt + 1;
    if (bus.ack != 4'b0) ack_cnt <= ack_cnt + 1;
    if (bus.tx_start && bus.tx_busy) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame on the main instance: wait for the start, check the grant, wait for the ack,
  // check mask/latency/error flag, drop the request and optionally re-raise it a cycle later.
  task automatic do_frame(input logic [3:0] exp_ack, input int exp_gid, input logic [7:0] exp_data,
                          input int exp_lat, input logic exp_err, input bit reraise);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      tick();
      n++;
      seen = bus.tx_start;
    end
    chk("start_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("grant_id", 32'(bus.grant_id), 32'(exp_gid));
      chk("tx_data", 32'(bus.tx_data), 32'(exp_data));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
        tick();
        n++;
        seen = (bus.ack != 4'b0);
      end
      chk("ack_seen", 32'(seen), 32'd1);
      if (seen) begin
        chk("ack_mask", 32'(bus.ack), 32'(exp_ack));
        chk("ack_latency", 32'(n), 32'(exp_lat));
        chk("err_at_ack", 32'(bus.err_timeout), 32'(exp_err));
        bus.req = bus.req & ~exp_ack;
        tick();
        chk("ack_one_cycle", 32'(bus.ack), 32'd0);
        if (reraise) bus.req = bus.req | exp_ack;
      end
    end
  endtask

  initial begin
    int n;
    int saved;
    bit seen;
    rst_n = 1'b0;
    bus.req = 4'b0;
    bus.req_data = {8'h3D, 8'hA5, 8'h5A, 8'hC3};
    bus.clr_err = 1'b0;
    bus0.req = 4'b0;
    bus0.req_data = {8'h11, 8'h22, 8'h77, 8'h44};
    bus0.clr_err = 1'b0;
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    model_en = 1'b1;

    // Contention: all four held, each re-raises after its ack.
    bus.req = 4'b1111;
    do_frame(4'b0001, 0, 8'hC3, 24, 1'b0, 1'b1);
    do_frame(4'b0010, 1, 8'h5A, 24, 1'b0, 1'b1);
    do_frame(4'b0100, 2, 8'hA5, 24, 1'b0, 1'b1);
    do_frame(4'b1000, 3, 8'h3D, 24, 1'b0, 1'b1);
    do_frame(4'b0001, 0, 8'hC3, 24, 1'b0, 1'b1);
    do_frame(4'b0010, 1, 8'h5A, 24, 1'b0, 1'b0);
    bus.req = 4'b0;
    chk("contention_acks", 32'(ack_cnt), 32'd6);
    chk("contention_starts", 32'(start_cnt), 32'd6);

    // Single request, then the two gap cycles before idle.
    saved = start_cnt;
    bus.req = 4'b0100;
    do_frame(4'b0100, 2, 8'hA5, 24, 1'b0, 1'b0);
    chk("gap_busy_0", 32'(bus.busy), 32'd1);
    tick();
    chk("gap_busy_1", 32'(bus.busy), 32'd1);
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("single_start_pulses", 32'(start_cnt), 32'(saved + 1));

    // Wrap priority: after 3 completes, 0 wins over 3.
    bus.req = 4'b1000;
    do_frame(4'b1000, 3, 8'h3D, 24, 1'b0, 1'b0);
    bus.req = 4'b1001;
    do_frame(4'b0001, 0, 8'hC3, 24, 1'b0, 1'b0);
    do_frame(4'b1000, 3, 8'h3D, 24, 1'b0, 1'b0);

    // Watchdog: transmitter never goes busy.
    model_en = 1'b0;
    bus.req = 4'b0001;
    do_frame(4'b0001, 0, 8'hC3, 17, 1'b1, 1'b0);
    chk("err_sticky", 32'(bus.err_timeout), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    chk("err_cleared", 32'(bus.err_timeout), 32'd0);
    // Clear held through a second expiry: the set wins, the clear takes it next cycle.
    bus.req = 4'b0001;
    do_frame(4'b0001, 0, 8'hC3, 17, 1'b1, 1'b0);
    chk("err_after_set_wins", 32'(bus.err_timeout), 32'd0);
    bus.clr_err = 1'b0;
    model_en = 1'b1;

    // Reset mid-frame (in WAIT_DONE).
    bus.req = 4'b0100;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      tick();
      n++;
      seen = bus.tx_start;
    end
    chk("midframe_start_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("midframe_busy", 32'(bus.busy), 32'd1);
    saved = ack_cnt;
    rst_n = 1'b0;
    model_en = 1'b0;
    #1;
    chk("mrst_ack", 32'(bus.ack), 32'd0);
    chk("mrst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mrst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("mrst_grant", 32'(bus.grant_id), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0110;
    tick();
    tick();
    tick();
    chk("mrst_no_ack", 32'(ack_cnt), 32'(saved));
    rst_n = 1'b1;
    model_en = 1'b1;
    do_frame(4'b0010, 1, 8'h5A, 24, 1'b0, 1'b0);
    do_frame(4'b0100, 2, 8'hA5, 24, 1'b0, 1'b0);

    // GAP_CYCLES=0 instance: req[1] held across two frames.
    bus0.req = 4'b0010;
    for (int f = 0; f < 2; f++) begin
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
        tick();
        n++;
        seen = bus0.tx_start;
      end
      chk("g0_start_seen", 32'(seen), 32'd1);
      if (f == 1) chk("g0_ack_to_start", 32'(n), 32'd2);
      chk("g0_grant", 32'(bus0.grant_id), 32'd1);
      chk("g0_tx_data", 32'(bus0.tx_data), 32'h77);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
        tick();
        n++;
        seen = (bus0.ack != 4'b0);
      end
      chk("g0_ack_seen", 32'(seen), 32'd1);
      chk("g0_ack_mask", 32'(bus0.ack), 32'h2);
      if (f == 1) bus0.req = 4'b0;
    end
    tick();
    tick();
    chk("g0_idle", 32'(bus0.busy), 32'd0);

    chk("start_busy_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter between NREQ independent requesters using round-robin arbitration. Each requester presents a byte with a level request. The arbiter selects one requester, latches its byte, and pulses the transmitter's start. It then tracks the transmitter's busy flag and returns a one-cycle acknowledge when the frame completes. A start-acknowledge watchdog flags a transmitter that never goes busy.

Parameters:
NREQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index (must satisfy 2**IDX_W >= NREQ)
ACK_TIMEOUT, 16, cycles allowed in WAIT_BUSY for tx_busy to rise
GAP_CYCLES, 2, idle cycles inserted after each frame before the next grant (0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  level request per requester; held until matching ack
req_data  input  8*NREQ  byte per requester, requester i at bits [8i+7:8i]; stable while req[i]
ack  output  NREQ  one-cycle pulse to granted requester on completion or timeout
tx_data  output  8  latched byte to transmitter; stable from LAUNCH until next grant
tx_start  output  1  one-cycle start pulse to transmitter
tx_busy  input  1  transmitter busy, high for the whole frame
grant_id  output  IDX_W  index of current or last granted requester
busy  output  1  high in every state except IDLE
err_timeout  output  1  sticky; set on watchdog expiry
clr_err  input  1  synchronous clear of err_timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ack=0; tx_start=0; tx_data=8'h00; grant_id=0; busy=0; err_timeout=0; rr pointer=NREQ-1, so requester 0 has first priority; counters=0.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from (ptr+1) mod NREQ upward with wrap.
  - Load grant_id and tx_data from the picked requester's req_data, then go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: tx_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT_BUSY.
  - Latency: req sampled high in IDLE at edge k gives tx_start high during cycle k+1.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else increment the counter. When the counter reaches ACK_TIMEOUT-1 without tx_busy, set err_timeout and go to COMPLETE. The frame is abandoned and the requester is still acked.
- WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to COMPLETE.
- COMPLETE:
  - ack[grant_id]=1 for this one cycle; ptr<=grant_id.
  - Go to GAP if GAP_CYCLES>0, else go to IDLE.
- GAP: count GAP_CYCLES cycles with no grant, then go to IDLE.
- Requester contract: req[i] deasserts on the edge where ack[i] is sampled high. The arbiter never re-grants from COMPLETE directly, so a dropped req is always seen before the next arbitration.
- A req bit that drops while not granted is simply not selected. A granted requester dropping req early has no effect; the latched byte is still sent and ack is still pulsed.
- clr_err=1 clears err_timeout. If expiry and clr_err occur in the same cycle, the set wins.
- Round-robin fairness: with all NREQ requests held continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 frames.
- Reset mid-frame returns to IDLE immediately. tx_start is not reissued, no ack is produced, and pending requests are re-arbitrated after reset release from requester 0.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, model busy 3 cycles after start for 20 cycles -> tx_start one pulse, tx_data=8'hA5, grant_id=2, ack=4'b0100 one cycle after busy falls, busy back to 0 after GAP.
- Contention: req=4'b1111 held, each requester re-raises after ack -> grant order 0,1,2,3,0,1; exactly one ack per frame; tx_start pulses never overlap a busy frame.
- Wrap priority: after grant_id=3 completes, req=4'b1001 -> next grant is 0, then 3.
- Watchdog: tx_busy tied 0, req=4'b0001 -> err_timeout=1 after ACK_TIMEOUT cycles in WAIT_BUSY, ack[0] pulses; clr_err=1 clears it next cycle.
- Reset mid-frame: assert reset=0 during WAIT_DONE -> all outputs at reset values immediately, no ack; after release with req=4'b0010 -> grant_id=1, normal frame.
- Back-to-back with GAP_CYCLES=0: req[1] held across two frames -> COMPLETE to IDLE to LAUNCH, minimum 2 cycles between ack and next tx_start.
